edge_detector_bank: RTL

//  Multi-channel edge detector: synchronises WIDTH async inputs, detects rising/falling/both

---
 rtl/edge_detector_bank.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/edge_detector_bank.sv
// edge_detector_bank
//   Multi-channel edge detector sitting between board I/O and CPU registers. Each of the
//   WIDTH asynchronous inputs is synchronised, optionally debounced, and watched for
//   rising/falling/both edges according to a runtime mode. A detected edge gives a 1-clock
//   pulse, sets a sticky flag, bumps a saturating per-channel counter and can raise an
//   interrupt.
//
//   Build option: define DEBOUNCE_EN to insert a per-channel stability filter of DB_CYCLES
//   clocks between the synchroniser and the edge logic. Without it, DB_CYCLES is unused.
//
// Ports
//   clk_i       system clock
//   rst_i       synchronous, active-high reset
//   signal_i    asynchronous inputs, one per channel
//   mode_i      per-channel mode at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   mask_i      per-channel interrupt enable
//   clear_i     per-channel sticky-flag clear (level, acts every cycle it is high)
//   cnt_sel_i   channel whose counter is shown on cnt_o
//   cnt_clr_i   clear the counter of channel cnt_sel_i
//   pulse_o     1-clock pulse per detected edge
//   detected_o  sticky edge flags
//   irq_o       registered OR of (detected_o & mask_i)
//   cnt_o       registered event count of the selected channel (0 if out of range)

module edge_detector_bank #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DB_CYCLES   = 4,
    localparam int unsigned SEL_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WIDTH-1:0]     signal_i,
    input  logic [2*WIDTH-1:0]   mode_i,
    input  logic [WIDTH-1:0]     mask_i,
    input  logic [WIDTH-1:0]     clear_i,
    input  logic [SEL_W-1:0]     cnt_sel_i,
    input  logic                 cnt_clr_i,
    output logic [WIDTH-1:0]     pulse_o,
    output logic [WIDTH-1:0]     detected_o,
    output logic                 irq_o,
    output logic [CNT_W-1:0]     cnt_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    // Synchroniser chain; stage 0 samples the raw asynchronous inputs.
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= signal_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] level;

    assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_EN
    localparam int unsigned DbW = $clog2(DB_CYCLES + 1);

    logic [WIDTH-1:0] filt_q;
    logic [DbW-1:0]   db_cnt_q [WIDTH];

    // The filtered level only moves once the synchronised input has disagreed with it for
    // DB_CYCLES consecutive clocks; any agreement restarts the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_s[i] != filt_q[i]) begin
                    if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
                        filt_q[i]   <= sync_s[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign level = filt_q;
`else
    assign level = sync_s;
`endif

    // Previous level tracks every cycle regardless of mode, so enabling a mode later never
    // sees stale history as an edge.
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

    always_comb begin
        edge_hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_hit[i] = (mode_i[2*i] & rise[i]) | (mode_i[2*i+1] & fall[i]);
        end
    end

    // Counter selection and per-channel counter next state.
    logic             sel_valid;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    assign sel_valid = (32'(cnt_sel_i) < WIDTH);

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr_i && sel_valid && (cnt_sel_i == SEL_W'(i))) begin
                // A clear coinciding with an edge still counts that edge.
                cnt_d[i] = edge_hit[i] ? CNT_W'(1) : '0;
            end else if (edge_hit[i] && (cnt_q[i] != CntMax)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q     <= '0;
            pulse_o    <= '0;
            detected_o <= '0;
            irq_o      <= 1'b0;
            cnt_o      <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            prev_q     <= level;
            pulse_o    <= edge_hit;
            // Set wins over a simultaneous clear.
            detected_o <= edge_hit | (detected_o & ~clear_i);
            irq_o      <= |(detected_o & mask_i);
            cnt_o      <= sel_valid ? cnt_q[cnt_sel_i] : '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
